// File: rtl/siso_shift_sequencer.sv
// Serialises a parallel word LSB-first through an external SISO DFF chain and reassembles it.
// Optional loopback compare against a shadow copy of the word: define SISO_LOOPBACK_CHECK_EN.
module siso_shift_sequencer #(
    parameter int WIDTH       = 8,
    parameter int CHAIN_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sr_serial_in,
    input  logic             sr_serial_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + CHAIN_DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH + CHAIN_DEPTH - 1);
    localparam logic [CW-1:0] W_C  = CW'(WIDTH);
    localparam logic [CW-1:0] D_C  = CW'(CHAIN_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] rx;
    logic [WIDTH:0]   rx_cat;
    logic             accept;
    logic             running;

    assign rx_cat   = {sr_serial_out, rx};
    assign out_data = rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        sr_serial_in = 1'b0;
        accept       = 1'b0;
        running      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy         = 1'b1;
                running      = 1'b1;
                sr_serial_in = (cnt < W_C) & tx[0];
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Capture waits CHAIN_DEPTH cycles so stale chain contents never reach rx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tx  <= '0;
            rx  <= '0;
        end else if (accept) begin
            cnt <= '0;
            tx  <= in_data;
        end else if (running) begin
            cnt <= cnt + 1'b1;
            tx  <= tx >> 1;
            if (cnt >= D_C) begin
                rx <= rx_cat[WIDTH:1];
            end
        end
    end

`ifdef SISO_LOOPBACK_CHECK_EN
    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (accept) begin
            shadow <= in_data;
        end
    end

    assign err = out_valid & (rx != shadow);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_shift_sequencer.sv
// Scoreboard bench for siso_shift_sequencer with a behavioural 4-stage chain.
// Checks err against SISO_LOOPBACK_CHECK_EN when that macro is defined.
module tb_siso_shift_sequencer;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int LAT = W + D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         stuck = 1'b0;
    logic         in_ready;
    logic         sr_serial_in;
    logic         sr_serial_out;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;
    logic         err;

    siso_shift_sequencer #(.WIDTH(W), .CHAIN_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .sr_serial_in (sr_serial_in),
        .sr_serial_out(sr_serial_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // External chain, no reset, stage 2 output can be stuck at 1.
    logic [D-1:0] ch = 4'b1011;
    logic         s2q;
    assign s2q = stuck ? 1'b1 : ch[1];
    always @(posedge clk) begin
        ch[0] <= sr_serial_in;
        ch[1] <= ch[0];
        ch[2] <= s2q;
        ch[3] <= ch[2];
    end
    assign sr_serial_out = ch[D-1];

    typedef struct {
        logic [W-1:0] exp;
        logic [W-1:0] sent;
        int           acc;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    hs_edge = -1;
    bit    b2b_check = 1'b0;
    logic  prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic exp_err(input item_t it);
`ifdef SISO_LOOPBACK_CHECK_EN
        return it.exp != it.sent;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_ov = 1'b0;
            chk("reset_outs", {27'd0, in_ready, out_valid, busy, sr_serial_in, err},
                32'b10000);
            chk("reset_data", 32'(out_data), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    if (!prev_ov) chk("latency", 32'(cyc - q[0].acc), 32'(LAT));
                    chk("out_data", 32'(out_data), 32'(q[0].exp));
                    chk("err", 32'(err), 32'(exp_err(q[0])));
                    if (out_ready) begin
                        hs_edge = cyc + 1;
                        void'(q.pop_front());
                    end
                end
            end
            prev_ov = out_valid;
            if (in_valid && in_ready) begin
                if (b2b_check) begin
                    chk("b2b_gap", 32'(cyc + 1 - hs_edge), 32'd1);
                    b2b_check = 1'b0;
                end
                q.push_back('{exp: stuck ? {W{1'b1}} : in_data,
                              sent: in_data, acc: cyc + 1});
            end
        end
    end

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout, wanted event within bound", name);
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) timeout("accept");
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] data, input bit serial_chk);
        logic [LAT-1:0] got;
        logic [LAT-1:0] want;
        in_data  = data;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        if (serial_chk) begin
            got  = '0;
            want = LAT'(data);
            for (int i = 0; i < LAT; i++) begin
                @(negedge clk);
                got[i] = sr_serial_in;
            end
            chk("serial_in", 32'(got), 32'(want));
        end
    endtask

    task automatic wait_ov();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout("out_valid");
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("idle");
        @(posedge clk);
        #1;
    endtask

    task automatic backpressure(input int hold);
        wait_ov();
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [W-1:0] d;
        int           hold;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        out_ready = 1'b1;
        send(8'hA5, 1'b1);
        wait_idle();

        out_ready = 1'b0;
        send(8'h3C, 1'b1);
        backpressure(5);
        wait_idle();

        in_data  = 8'hFF;
        in_valid = 1'b1;
        wait_accept();
        in_data   = 8'h01;
        b2b_check = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_idle();

        in_data  = 8'hF0;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h0F, 1'b1);
        wait_idle();

        stuck = 1'b1;
        send(8'h00, 1'b1);
        wait_idle();
        stuck = 1'b0;
        send(8'h00, 1'b1);
        wait_idle();

        for (int k = 0; k < 24; k++) begin
            d         = W'($urandom);
            hold      = $urandom_range(0, 4);
            out_ready = ($urandom_range(0, 2) != 0);
            send(d, 1'b1);
            if (!out_ready) backpressure(hold);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
